// File: rtl/sa_wb_cache.sv
// N-way set-associative write-back, write-allocate cache.
// Round-robin replacement per set, dirty-line write-back, byte strobes.
module sa_wb_cache #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int SETS           = 256,
    parameter int WAYS           = 2
) (
    input  logic                             clk,
    input  logic                             r,
    input  logic                             cpu2cache_valid,
    input  logic                             cpu2cache_rw,
    input  logic [ADDR_W-1:0]                cpu2cache_addr,
    input  logic [DATA_W-1:0]                cpu2cache_data,
    input  logic [DATA_W/8-1:0]              cpu2cache_wstrb,
    output logic [DATA_W-1:0]                cache2cpu_data,
    output logic                             cache2cpu_ready,
    output logic                             cache2mem_valid,
    output logic                             cache2mem_rw,
    output logic [ADDR_W-1:0]                cache2mem_addr,
    output logic [DATA_W*WORDS_PER_LINE-1:0] cache2mem_data,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] mem2cache_data,
    input  logic                             mem2cache_ready
);
    localparam int BYTES    = DATA_W / 8;
    localparam int LINE_W   = DATA_W * WORDS_PER_LINE;
    localparam int WSEL_W   = $clog2(WORDS_PER_LINE);
    localparam int BOFF_W   = $clog2(BYTES);
    localparam int OFFSET_W = WSEL_W + BOFF_W;
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t r_state, w_state_n;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [WAY_W-1:0]  r_rr    [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_line  [SETS][WAYS];

    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [BYTES-1:0]  r_wstrb;
    logic [WAY_W-1:0]  r_victim;
    logic              r_full;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [WSEL_W-1:0]  w_wsel;
    logic               w_hit;
    logic [WAY_W-1:0]   w_hway;
    logic [WAY_W-1:0]   w_vict;
    logic               w_full;
    logic [WAY_W-1:0]   w_rr_inc;
    logic [LINE_W-1:0]  w_hline;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_merged;

    assign w_tag  = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx  = r_addr[OFFSET_W +: INDEX_W];
    assign w_wsel = r_addr[BOFF_W +: WSEL_W];

    always_comb begin
        w_hit  = 1'b0;
        w_hway = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit  = 1'b1;
                w_hway = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; the rr pointer only matters for a full set.
    always_comb begin
        w_full = &r_valid[w_idx];
        w_vict = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_vict = WAY_W'(w);
        end
        w_rr_inc = (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + 1'b1;
    end

    assign w_hline = r_line[w_idx][w_hway];
    assign w_word  = w_hline[w_wsel*DATA_W +: DATA_W];

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < BYTES; b++) begin
            if (r_wstrb[b]) w_merged[b*8 +: 8] = r_data[b*8 +: 8];
        end
    end

    always_comb begin
        w_state_n       = r_state;
        cache2cpu_data  = '0;
        cache2cpu_ready = 1'b0;
        cache2mem_valid = 1'b0;
        cache2mem_rw    = 1'b0;
        cache2mem_addr  = '0;
        cache2mem_data  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (cpu2cache_valid) w_state_n = S_COMPARE;
            end
            S_COMPARE: begin
                if (w_hit) begin
                    cache2cpu_ready = 1'b1;
                    cache2cpu_data  = r_rw ? w_merged : w_word;
                    w_state_n       = S_IDLE;
                end else if (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) begin
                    w_state_n = S_WRITEBACK;
                end else begin
                    w_state_n = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                cache2mem_valid = 1'b1;
                cache2mem_rw    = 1'b1;
                cache2mem_addr  = {r_tag[w_idx][r_victim], w_idx, {OFFSET_W{1'b0}}};
                cache2mem_data  = r_line[w_idx][r_victim];
                if (mem2cache_ready) w_state_n = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                cache2mem_valid = 1'b1;
                cache2mem_addr  = {w_tag, w_idx, {OFFSET_W{1'b0}}};
                if (mem2cache_ready) w_state_n = S_COMPARE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            r_state <= S_IDLE;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_rr[s]    <= '0;
            end
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_wstrb  <= '0;
            r_victim <= '0;
            r_full   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (r_state == S_IDLE && cpu2cache_valid) begin
                r_rw    <= cpu2cache_rw;
                r_addr  <= cpu2cache_addr;
                r_data  <= cpu2cache_data;
                r_wstrb <= cpu2cache_wstrb;
            end
            if (r_state == S_COMPARE) begin
                if (w_hit) begin
                    if (r_rw) r_dirty[w_idx][w_hway] <= 1'b1;
                end else begin
                    r_victim <= w_vict;
                    r_full   <= w_full;
                end
            end
            if (r_state == S_ALLOCATE && mem2cache_ready) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
                if (r_full) r_rr[w_idx] <= w_rr_inc;
            end
        end
    end

    // Tag and line storage carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (r) begin
            if (r_state == S_COMPARE && w_hit && r_rw) begin
                r_line[w_idx][w_hway][w_wsel*DATA_W +: DATA_W] <= w_merged;
            end
            if (r_state == S_ALLOCATE && mem2cache_ready) begin
                r_line[w_idx][r_victim] <= mem2cache_data;
                r_tag[w_idx][r_victim]  <= w_tag;
            end
        end
    end
endmodule

// File: tb/tb_sa_wb_cache.sv
// Directed bench for sa_wb_cache with queue-based scoreboard.
// Memory model returns line L(a) = {a+12, a+8, a+4, a}.
module tb_sa_wb_cache;
    typedef struct packed {
        logic         rw;
        logic [31:0]  addr;
        logic [127:0] data;
    } mreq_t;

    logic         clk;
    logic         r;
    logic         cpu2cache_valid;
    logic         cpu2cache_rw;
    logic [31:0]  cpu2cache_addr;
    logic [31:0]  cpu2cache_data;
    logic [3:0]   cpu2cache_wstrb;
    logic [31:0]  cache2cpu_data;
    logic         cache2cpu_ready;
    logic         cache2mem_valid;
    logic         cache2mem_rw;
    logic [31:0]  cache2mem_addr;
    logic [127:0] cache2mem_data;
    logic [127:0] mem2cache_data;
    logic         mem2cache_ready;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_cpu [$];
    mreq_t       exp_mem [$];

    sa_wb_cache dut (
        .clk             (clk),
        .r               (r),
        .cpu2cache_valid (cpu2cache_valid),
        .cpu2cache_rw    (cpu2cache_rw),
        .cpu2cache_addr  (cpu2cache_addr),
        .cpu2cache_data  (cpu2cache_data),
        .cpu2cache_wstrb (cpu2cache_wstrb),
        .cache2cpu_data  (cache2cpu_data),
        .cache2cpu_ready (cache2cpu_ready),
        .cache2mem_valid (cache2mem_valid),
        .cache2mem_rw    (cache2mem_rw),
        .cache2mem_addr  (cache2mem_addr),
        .cache2mem_data  (cache2mem_data),
        .mem2cache_data  (mem2cache_data),
        .mem2cache_ready (mem2cache_ready)
    );

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    assign mem2cache_data = line_of(cache2mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (cache2cpu_ready === 1'b1) begin
            if (exp_cpu.size() == 0) begin
                chk("cpu_unexpected_ready", 1, 0);
            end else begin
                e = exp_cpu.pop_front();
                chk("cpu_rdata", cache2cpu_data, e);
            end
        end
    end

    always @(negedge clk) begin
        mreq_t m;
        if (cache2mem_valid === 1'b1 && mem2cache_ready === 1'b1) begin
            if (exp_mem.size() == 0) begin
                chk("mem_unexpected_req", cache2mem_addr, 32'hFFFF_FFFF);
            end else begin
                m = exp_mem.pop_front();
                chk("mem_rw", cache2mem_rw, m.rw);
                chk("mem_addr", cache2mem_addr, m.addr);
                if (m.rw) chk("mem_wb_data", cache2mem_data, m.data);
            end
        end
    end

    task automatic push_mem(input logic rw, input logic [31:0] a,
                            input logic [127:0] d);
        mreq_t m;
        m.rw   = rw;
        m.addr = a;
        m.data = d;
        exp_mem.push_back(m);
    endtask

    task automatic issue(input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        @(posedge clk);
        #1;
        cpu2cache_valid = 1'b1;
        cpu2cache_rw    = rw;
        cpu2cache_addr  = a;
        cpu2cache_data  = d;
        cpu2cache_wstrb = s;
        @(posedge clk);
        #1;
        cpu2cache_valid = 1'b0;
    endtask

    task automatic wait_ready(input int exp_lat, input string name);
        int lat = 0;
        bit got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (cache2cpu_ready === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        else if (exp_lat != 0) chk(name, lat, exp_lat);
    endtask

    task automatic wait_mem(input logic want_rw, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cache2mem_valid === 1'b1 && cache2mem_rw === want_rw) got = 1'b1;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cpu_ready"}, cache2cpu_ready, 0);
        chk({tag, "_cpu_data"}, cache2cpu_data, 0);
        chk({tag, "_mem_valid"}, cache2mem_valid, 0);
        chk({tag, "_mem_rw"}, cache2mem_rw, 0);
        chk({tag, "_mem_addr"}, cache2mem_addr, 0);
        chk({tag, "_mem_data"}, cache2mem_data, 0);
    endtask

    initial begin
        logic [31:0] st_addr;
        r               = 1'b0;
        cpu2cache_valid = 1'b0;
        cpu2cache_rw    = 1'b0;
        cpu2cache_addr  = '0;
        cpu2cache_data  = '0;
        cpu2cache_wstrb = '0;
        mem2cache_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        r = 1'b1;

        // 1: cold read fills way0
        push_mem(1'b0, 32'h0000_0000, '0);
        exp_cpu.push_back(32'h0000_0000);
        issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
        wait_ready(3, "t1_latency");

        // 2: hit in the same line
        exp_cpu.push_back(32'h0000_0004);
        issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        wait_ready(1, "t2_latency");

        // 3: write miss into invalid way1, low halfword merged
        push_mem(1'b0, 32'h0000_1000, '0);
        exp_cpu.push_back(32'h0000_FFFF);
        issue(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'b0011);
        wait_ready(3, "t3_latency");

        // 4: clean eviction of way0, then dirty eviction of way1
        push_mem(1'b0, 32'h0000_2000, '0);
        exp_cpu.push_back(32'h0000_2000);
        issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        wait_ready(3, "t4a_latency");
        push_mem(1'b1, 32'h0000_1000,
                 {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_FFFF});
        push_mem(1'b0, 32'h0000_3000, '0);
        exp_cpu.push_back(32'h0000_3000);
        issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        wait_ready(4, "t4b_latency");

        // 5: memory stalls during ALLOCATE
        mem2cache_ready = 1'b0;
        push_mem(1'b0, 32'h0000_4000, '0);
        exp_cpu.push_back(32'h0000_4000);
        issue(1'b0, 32'h0000_4000, 32'h0, 4'h0);
        wait_mem(1'b0, "t5_fill");
        st_addr = cache2mem_addr;
        chk("t5_fill_addr", st_addr, 32'h0000_4000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_stall_valid", cache2mem_valid, 1);
            chk("t5_stall_rw", cache2mem_rw, 0);
            chk("t5_stall_addr", cache2mem_addr, 32'h0000_4000);
            chk("t5_stall_cpu_ready", cache2cpu_ready, 0);
        end
        @(posedge clk);
        #1;
        mem2cache_ready = 1'b1;
        wait_ready(0, "t5_done");

        // 6: dirty the 0x3000 line, then reset during its write-back
        exp_cpu.push_back(32'hA5A5_A5A5);
        issue(1'b1, 32'h0000_3004, 32'hA5A5_A5A5, 4'hF);
        wait_ready(1, "t6_whit_latency");
        mem2cache_ready = 1'b0;
        issue(1'b0, 32'h0000_5000, 32'h0, 4'h0);
        wait_mem(1'b1, "t6_wb");
        chk("t6_wb_addr", cache2mem_addr, 32'h0000_3000);
        chk("t6_wb_data", cache2mem_data,
            {32'h0000_300C, 32'h0000_3008, 32'hA5A5_A5A5, 32'h0000_3000});
        r = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_zero("t6_reset");
        r = 1'b1;
        mem2cache_ready = 1'b1;
        push_mem(1'b0, 32'h0000_2000, '0);
        exp_cpu.push_back(32'h0000_2000);
        issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        wait_ready(3, "t6_post_latency");

        repeat (3) @(posedge clk);
        chk("cpu_queue_drained", exp_cpu.size(), 0);
        chk("mem_queue_drained", exp_mem.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
